// File: rtl/macro_counter_bank.sv
// macro_counter_bank: multi-channel counter/compare register bank.
// Each channel keeps a counter (cnt) and a reference value (tmp). An accepted
// command clears, loads tmp, increments or captures cnt on one channel and
// produces exactly one registered response carrying the post-op compare result.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   command handshake (in_ready = !out_valid || out_ready)
//   in_chan, in_op, din   target channel, operation (0 CLEAR, 1 LOAD, 2 INC,
//                         3 CAPTURE), operand for LOAD/CAPTURE
//   out_valid / out_ready response handshake
//   out_chan, dout        response channel and value (cnt' if match else tmp')
//   out_match, out_wrap   post-op cnt == tmp, INC carried out of WIDTH bits
//   out_err               channel index was out of range
module macro_counter_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned STEP     = 1,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_chan,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] dout,
    output logic             out_match,
    output logic             out_wrap,
    output logic             out_err
);

    localparam logic [1:0] OP_CLEAR   = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_INC     = 2'd2;
    localparam logic [1:0] OP_CAPTURE = 2'd3;

    // STEP is reduced modulo 2^WIDTH by truncation.
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] cnt_q [CHANNELS];
    logic [WIDTH-1:0] tmp_q [CHANNELS];

    logic             accept_c;
    logic             in_range_c;
    logic             wrap_c;
    logic             match_c;
    logic [WIDTH-1:0] cur_cnt_c;
    logic [WIDTH-1:0] cur_tmp_c;
    logic [WIDTH-1:0] new_cnt_c;
    logic [WIDTH-1:0] new_tmp_c;

    // Single output register: a new command may enter whenever the slot
    // is empty or is being drained this cycle.
    assign in_ready   = !out_valid || out_ready;
    assign accept_c   = in_valid && in_ready;
    assign in_range_c = 32'(in_chan) < CHANNELS;

    // Read the addressed channel; out-of-range indices read zero.
    always_comb begin
        cur_cnt_c = '0;
        cur_tmp_c = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (in_chan == CW'(c)) begin
                cur_cnt_c = cnt_q[c];
                cur_tmp_c = tmp_q[c];
            end
        end
    end

    // Post-op channel values and compare result.
    always_comb begin
        new_cnt_c = cur_cnt_c;
        new_tmp_c = cur_tmp_c;
        wrap_c    = 1'b0;
        case (in_op)
            OP_CLEAR:   new_cnt_c = '0;
            OP_LOAD:    new_tmp_c = din;
            OP_INC:     {wrap_c, new_cnt_c} = {1'b0, cur_cnt_c} + {1'b0, STEP_W};
            OP_CAPTURE: new_cnt_c = din;
            default:    new_cnt_c = cur_cnt_c;
        endcase
        match_c = (new_cnt_c == new_tmp_c);
    end

    // Channel state: only the addressed in-range channel is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
                tmp_q[c] <= '0;
            end
        end else if (accept_c && in_range_c) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (in_chan == CW'(c)) begin
                    cnt_q[c] <= new_cnt_c;
                    tmp_q[c] <= new_tmp_c;
                end
            end
        end
    end

    // Response register: load on accept, retire on out_ready, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            dout      <= '0;
            out_match <= 1'b0;
            out_wrap  <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            out_chan  <= in_chan;
            if (in_range_c) begin
                dout      <= match_c ? new_cnt_c : new_tmp_c;
                out_match <= match_c;
                out_wrap  <= wrap_c;
                out_err   <= 1'b0;
            end else begin
                dout      <= '0;
                out_match <= 1'b0;
                out_wrap  <= 1'b0;
                out_err   <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_macro_counter_bank.sv
// Testbench for macro_counter_bank (WIDTH=8, CHANNELS=3, STEP=1).
// Directed vector table applied at full rate, then backpressure, a random
// stream against a small reference model, and asynchronous reset with a
// response pending.
module tb_macro_counter_bank;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned STEP     = 1;
    localparam int unsigned CW       = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_chan;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_chan;
    logic [WIDTH-1:0] dout;
    logic             out_match;
    logic             out_wrap;
    logic             out_err;

    always #5 clk = ~clk;

    macro_counter_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .STEP     (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chan   (in_chan),
        .in_op     (in_op),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .dout      (dout),
        .out_match (out_match),
        .out_wrap  (out_wrap),
        .out_err   (out_err)
    );

    typedef struct {
        logic [CW-1:0]    chan;
        logic [1:0]       op;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        logic             match;
        logic             wrap;
        logic             err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_cnt [CHANNELS];
    logic [WIDTH-1:0] m_tmp [CHANNELS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply one accepted command, return expected response.
    task automatic model_step(input logic [CW-1:0] ch, input logic [1:0] op,
                              input logic [WIDTH-1:0] d,
                              output logic [WIDTH-1:0] e_dout, output logic e_match,
                              output logic e_wrap, output logic e_err);
        logic [WIDTH:0] sum;
        logic [WIDTH-1:0] c, t;
        e_dout = '0; e_match = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
        if (32'(ch) >= CHANNELS) begin
            e_err = 1'b1;
        end else begin
            c = m_cnt[ch];
            t = m_tmp[ch];
            case (op)
                2'd0: c = '0;
                2'd1: t = d;
                2'd2: begin
                    sum    = {1'b0, c} + (WIDTH+1)'(STEP);
                    c      = sum[WIDTH-1:0];
                    e_wrap = sum[WIDTH];
                end
                default: c = d;
            endcase
            m_cnt[ch] = c;
            m_tmp[ch] = t;
            e_match   = (c == t);
            e_dout    = e_match ? c : t;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(CHANNELS); c++) begin
            m_cnt[c] = '0;
            m_tmp[c] = '0;
        end
    endtask

    task automatic drive(input logic [CW-1:0] ch, input logic [1:0] op, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_chan  = ch;
        in_op    = op;
        din      = d;
    endtask

    task automatic check_resp(input string tag, input logic [CW-1:0] ch,
                              input logic [WIDTH-1:0] e_dout, input logic e_match,
                              input logic e_wrap, input logic e_err);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(1'b1));
        check({tag, ".out_chan"},  32'(out_chan),  32'(ch));
        check({tag, ".dout"},      32'(dout),      32'(e_dout));
        check({tag, ".out_match"}, 32'(out_match), 32'(e_match));
        check({tag, ".out_wrap"},  32'(out_wrap),  32'(e_wrap));
        check({tag, ".out_err"},   32'(out_err),   32'(e_err));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(1'b0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(1'b1));
        check({tag, ".dout"},      32'(dout),      32'(0));
        check({tag, ".out_chan"},  32'(out_chan),  32'(0));
        check({tag, ".flags"},     32'({out_match, out_wrap, out_err}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] e_dout;
        logic e_match, e_wrap, e_err;
        logic [CW-1:0] r_ch;
        logic [1:0] r_op;
        logic [WIDTH-1:0] r_din;

        // chan, op, din, expected dout, match, wrap, err (from all-zero state)
        vecs[0]  = '{2'd0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}; // INC ch0: cnt1 tmp0
        vecs[1]  = '{2'd2, 2'd1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0}; // LOAD ch2: tmp5 cnt0
        vecs[2]  = '{2'd2, 2'd3, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0}; // CAPTURE ch2: cnt3
        vecs[3]  = '{2'd2, 2'd2, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0}; // INC ch2: cnt4
        vecs[4]  = '{2'd2, 2'd2, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0}; // INC ch2: cnt5 == tmp
        vecs[5]  = '{2'd1, 2'd3, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0}; // CAPTURE ch1: cnt FF
        vecs[6]  = '{2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}; // INC ch1 wraps to 0
        vecs[7]  = '{2'd1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}; // INC ch1: cnt1
        vecs[8]  = '{2'd1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}; // CLEAR ch1: 0 == 0
        vecs[9]  = '{2'd3, 2'd3, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1}; // CAPTURE ch3: error
        vecs[10] = '{2'd3, 2'd1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1}; // LOAD ch3: error
        vecs[11] = '{2'd2, 2'd2, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0}; // INC ch2: cnt6 tmp5
        vecs[12] = '{2'd0, 2'd1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0}; // LOAD ch0: cnt1 tmp2
        vecs[13] = '{2'd0, 2'd2, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0}; // INC ch0: cnt2 == tmp

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_chan   = '0;
        in_op     = '0;
        din       = '0;
        out_ready = 1'b1;
        model_reset();

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Directed table, one command per cycle.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].chan, vecs[i].op, vecs[i].din);
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(1'b1));
            model_step(vecs[i].chan, vecs[i].op, vecs[i].din, e_dout, e_match, e_wrap, e_err);
            @(posedge clk);
            #1;
            check_resp($sformatf("vec%0d", i), vecs[i].chan, vecs[i].dout,
                       vecs[i].match, vecs[i].wrap, vecs[i].err);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.out_valid", 32'(out_valid), 32'(1'b0));

        // Backpressure: INC ch0 (cnt 2->3, tmp 2), then stall with LOAD ch0 pending.
        out_ready = 1'b0;
        drive(2'd0, 2'd2, 8'h00);
        model_step(2'd0, 2'd2, 8'h00, e_dout, e_match, e_wrap, e_err);
        @(posedge clk);
        #1;
        check_resp("bp_first", 2'd0, 8'h02, 1'b0, 1'b0, 1'b0);
        drive(2'd0, 2'd1, 8'h03);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'(1'b0));
            @(posedge clk);
            #1;
            check_resp($sformatf("bp%0d.hold", k), 2'd0, 8'h02, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 32'(in_ready), 32'(1'b1));
        model_step(2'd0, 2'd1, 8'h03, e_dout, e_match, e_wrap, e_err);
        @(posedge clk);
        #1;
        check_resp("bp_second", 2'd0, 8'h03, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_drain.out_valid", 32'(out_valid), 32'(1'b0));

        // Full-rate random stream against the model.
        for (int i = 0; i < 16; i++) begin
            r_ch  = CW'($urandom_range(0, 3));
            r_op  = 2'($urandom_range(0, 3));
            r_din = WIDTH'($urandom_range(0, 255));
            drive(r_ch, r_op, r_din);
            model_step(r_ch, r_op, r_din, e_dout, e_match, e_wrap, e_err);
            @(posedge clk);
            #1;
            check_resp($sformatf("rnd%0d", i), r_ch, e_dout, e_match, e_wrap, e_err);
        end
        in_valid = 1'b0;

        // Reset while a response is pending: must vanish immediately.
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'd2, 2'd3, 8'h44);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pend.out_valid", 32'(out_valid), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("after_reset.out_valid", 32'(out_valid), 32'(1'b0));
        end

        // Channel state was cleared: INC ch2 gives cnt1 tmp0.
        drive(2'd2, 2'd2, 8'h00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_resp("cleared_ch2", 2'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
